// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the legal range of the data memory read latency.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int MEM_RD_LAT_MIN = 1;
    localparam int MEM_RD_LAT_MAX = 3;
    localparam int CNT_W          = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts and extends sub-word load data and
// merges sub-word store data into a read word (little-endian lanes).
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        signed_i,
    input  logic [31:0] mem_word_i,
    input  logic [15:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        shamt        = 5'd0;
        store_word_o = mem_word_i;
        case (size_i)
            SZ_BYTE: shamt = {lane_i, 3'b000};
            SZ_HALF: shamt = {lane_i[1], 4'b0000};
            default: shamt = 5'd0;
        endcase

        shifted     = mem_word_i >> shamt;
        load_data_o = shifted;
        case (size_i)
            SZ_BYTE: begin
                load_data_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
                store_word_o[shamt +: 8] = store_data_i[7:0];
            end
            SZ_HALF: begin
                load_data_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
                store_word_o[shamt +: 16] = store_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store front end for a word-wide Data_mem without byte enables; sub-word
// stores are read-modify-write. Define LSU_ALIGN_CHECK_EN to reject misaligned
// half/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] Data_address,
    output logic [31:0] Data_in,
    output logic        we,
    input  logic [31:0] Data_out
);

    lsu_state_e       state_q;
    logic             store_q;
    logic [1:0]       size_q;
    logic             signed_q;
    logic [1:0]       lane_q;
    logic [15:0]      wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      data_addr_q;
    logic [31:0]      data_in_q;
    logic             we_q;
    logic             resp_valid_q;
    logic [31:0]      resp_rdata_q;
    logic             resp_err_q;

    logic        misaligned;
    logic        req_err;
    logic [31:0] load_word;
    logic [31:0] store_word;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((req_size == SZ_HALF) && req_addr[0]) ||
                        ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    assign req_err   = (req_size == SZ_RSVD) || misaligned;
    assign req_ready = (state_q == S_IDLE) && !Reset;

    lsu_byte_lane u_byte_lane (
        .size_i       (size_q),
        .lane_i       (lane_q),
        .signed_i     (signed_q),
        .mem_word_i   (Data_out),
        .store_data_i (wdata_q),
        .load_data_o  (load_word),
        .store_word_o (store_word)
    );

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before this edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            store_q      <= 1'b0;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 16'h0;
            cnt_q        <= '0;
            data_addr_q  <= 32'h0;
            data_in_q    <= 32'h0;
            we_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        store_q  <= req_store;
                        size_q   <= req_size;
                        signed_q <= req_signed;
                        lane_q   <= req_addr[1:0];
                        wdata_q  <= req_wdata[15:0];
                        if (req_err) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            data_addr_q <= {req_addr[31:2], 2'b00};
                            if (req_store && (req_size == SZ_WORD)) begin
                                state_q   <= S_WR;
                                we_q      <= 1'b1;
                                data_in_q <= req_wdata;
                            end else begin
                                state_q <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    cnt_q   <= CNT_W'(MEM_RD_LAT - 1);
                    state_q <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // Data_out is valid in the last wait cycle; sample it then.
                    if (cnt_q == '0) begin
                        if (store_q) begin
                            state_q   <= S_WR;
                            we_q      <= 1'b1;
                            data_in_q <= store_word;
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= load_word;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_WR: begin
                    we_q         <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_rdata_q <= 32'h0;
                    resp_err_q   <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Data_address = data_addr_q;
    assign Data_in      = data_in_q;
    assign we           = we_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;

endmodule
